// File: rtl/debounce_array.sv
// Multi-channel inertial-delay debouncer with input synchronisers, separate
// rise/fall hold times, registered edge pulses and sticky change flags.
module debounce_array #(
  parameter int CHANNELS    = 8,
  parameter int CNT_WIDTH   = 8,
  parameter int RISE_THRESH = 10,
  parameter int FALL_THRESH = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] sig_in_i,
  input  logic [CHANNELS-1:0] clr_event_i,
  output logic [CHANNELS-1:0] sig_out_o,
  output logic [CHANNELS-1:0] rise_pulse_o,
  output logic [CHANNELS-1:0] fall_pulse_o,
  output logic [CHANNELS-1:0] event_flag_o
);

  localparam logic [CNT_WIDTH-1:0] RISE_LAST = CNT_WIDTH'(RISE_THRESH - 1);
  localparam logic [CNT_WIDTH-1:0] FALL_LAST = CNT_WIDTH'(FALL_THRESH - 1);

  logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]  sync_s;
  logic [CNT_WIDTH-1:0] cnt_q  [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d  [CHANNELS];
  logic [CHANNELS-1:0]  sig_out_q, sig_out_d;
  logic [CHANNELS-1:0]  rise_q, rise_d;
  logic [CHANNELS-1:0]  fall_q, fall_d;
  logic [CHANNELS-1:0]  flag_q, flag_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= {CHANNELS{RESET_LEVEL}};
      end
    end else begin
      sync_q[0] <= sig_in_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // The hold threshold follows the level the synced input is trying to reach.
  always_comb begin
    sig_out_d = sig_out_q;
    rise_d    = '0;
    fall_d    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] == sig_out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == (sync_s[i] ? RISE_LAST : FALL_LAST)) begin
        sig_out_d[i] = sync_s[i];
        rise_d[i]    = sync_s[i];
        fall_d[i]    = ~sync_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
    flag_d = (flag_q & ~clr_event_i) | rise_d | fall_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      sig_out_q <= {CHANNELS{RESET_LEVEL}};
      rise_q    <= '0;
      fall_q    <= '0;
      flag_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      sig_out_q <= sig_out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      flag_q    <= flag_d;
    end
  end

  assign sig_out_o    = sig_out_q;
  assign rise_pulse_o = rise_q;
  assign fall_pulse_o = fall_q;
  assign event_flag_o = flag_q;

endmodule

// File: tb/tb_debounce_array.sv
// Table-driven scoreboard bench for debounce_array at default parameters.
module tb_debounce_array;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sig_in;
  logic [7:0] clr_event;
  logic [7:0] sig_out, rise_pulse, fall_pulse, event_flag;

  debounce_array dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sig_in_i     (sig_in),
    .clr_event_i  (clr_event),
    .sig_out_o    (sig_out),
    .rise_pulse_o (rise_pulse),
    .fall_pulse_o (fall_pulse),
    .event_flag_o (event_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] flag;
  } exp_t;

  // One segment: inputs held for 'hold' cycles; channels in 'mask' toggle on cycle 'at' (0 = none).
  typedef struct {
    logic [7:0] in;
    logic [7:0] clr;
    logic       rst;
    int         hold;
    logic [7:0] mask;
    int         at;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[12];
  logic [7:0] exp_out  = 8'h00;
  logic [7:0] exp_flag = 8'h00;
  int         vectors     = 0;
  int         miscompares = 0;

  task automatic apply(input string tag, input vec_t v);
    exp_t e, got;
    for (int c = 1; c <= v.hold; c++) begin
      e.rise = 8'h00;
      e.fall = 8'h00;
      if (v.rst) begin
        exp_out  = 8'h00;
        exp_flag = 8'h00;
      end else begin
        exp_flag = exp_flag & ~v.clr;
        if (c == v.at) begin
          exp_out  = exp_out ^ v.mask;
          e.rise   = v.mask & exp_out;
          e.fall   = v.mask & ~exp_out;
          exp_flag = exp_flag | v.mask;
        end
      end
      e.out  = exp_out;
      e.flag = exp_flag;
      sig_in    = v.in;
      clr_event = v.clr;
      rst       = v.rst;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      got.out  = sig_out;
      got.rise = rise_pulse;
      got.fall = fall_pulse;
      got.flag = event_flag;
      vectors++;
      if (got != e) begin
        miscompares++;
        $display("FAIL %s cyc %0d: got out=%h rise=%h fall=%h flag=%h, expected out=%h rise=%h fall=%h flag=%h",
                 tag, c, got.out, got.rise, got.fall, got.flag, e.out, e.rise, e.fall, e.flag);
      end
    end
  endtask

  task automatic seg(input string tag, input logic [7:0] in, input logic [7:0] clr,
                     input logic r, input int hold, input logic [7:0] mask, input int at);
    vec_t v;
    v = '{in: in, clr: clr, rst: r, hold: hold, mask: mask, at: at};
    apply(tag, v);
  endtask

  initial begin
    tbl[0]  = '{in: 8'h00, clr: 8'h00, rst: 1'b1, hold: 3,  mask: 8'h00, at: 0};
    tbl[1]  = '{in: 8'h01, clr: 8'h00, rst: 1'b0, hold: 14, mask: 8'h01, at: 12};
    tbl[2]  = '{in: 8'h00, clr: 8'h00, rst: 1'b0, hold: 8,  mask: 8'h01, at: 6};
    tbl[3]  = '{in: 8'h04, clr: 8'h00, rst: 1'b0, hold: 13, mask: 8'h04, at: 12};
    tbl[4]  = '{in: 8'h00, clr: 8'h00, rst: 1'b0, hold: 5,  mask: 8'h00, at: 0};
    tbl[5]  = '{in: 8'h00, clr: 8'h04, rst: 1'b0, hold: 1,  mask: 8'h04, at: 1};
    tbl[6]  = '{in: 8'h00, clr: 8'h04, rst: 1'b0, hold: 1,  mask: 8'h00, at: 0};
    tbl[7]  = '{in: 8'h00, clr: 8'h01, rst: 1'b0, hold: 3,  mask: 8'h00, at: 0};
    tbl[8]  = '{in: 8'hFF, clr: 8'h00, rst: 1'b0, hold: 13, mask: 8'hFF, at: 12};
    tbl[9]  = '{in: 8'h00, clr: 8'hFF, rst: 1'b0, hold: 5,  mask: 8'h00, at: 0};
    tbl[10] = '{in: 8'h00, clr: 8'h00, rst: 1'b0, hold: 3,  mask: 8'hFF, at: 1};
    tbl[11] = '{in: 8'h00, clr: 8'hFF, rst: 1'b0, hold: 2,  mask: 8'h00, at: 0};

    sig_in    = 8'h00;
    clr_event = 8'h00;
    rst       = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply($sformatf("tbl%0d", i), tbl[i]);
    end

    // Channel 1 glitch: 9 high, 1 low, 9 high never reaches the rise threshold.
    seg("glitch_hi1", 8'h02, 8'h00, 1'b0, 9, 8'h00, 0);
    seg("glitch_lo",  8'h00, 8'h00, 1'b0, 1, 8'h00, 0);
    seg("glitch_hi2", 8'h02, 8'h00, 1'b0, 9, 8'h00, 0);
    seg("glitch_end", 8'h00, 8'h00, 1'b0, 4, 8'h00, 0);

    // Channel 4 toggling every cycle never settles.
    for (int t = 0; t < 20; t++) begin
      seg("toggle", (t % 2 == 0) ? 8'h10 : 8'h00, 8'h00, 1'b0, 1, 8'h00, 0);
    end
    seg("toggle_end", 8'h00, 8'h00, 1'b0, 4, 8'h00, 0);

    // Reset during a channel-3 count discards it; both channels need the full 12 clocks again.
    seg("pre_rise0", 8'h01, 8'h00, 1'b0, 12, 8'h01, 12);
    seg("count3",    8'h09, 8'h00, 1'b0, 9,  8'h00, 0);
    seg("mid_rst",   8'h09, 8'h00, 1'b1, 1,  8'h00, 0);
    seg("post_rst",  8'h09, 8'h00, 1'b0, 13, 8'h09, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
